rr_grant_encoder: RTL and testbench
===================================

Name: rr_grant_encoder

Overview:
- Round-robin arbiter for 8 requesters. Emits the binary index of the granted requester plus a valid flag.
- Sits directly upstream of the 3-to-8 decoder stage. gnt_idx[2], gnt_idx[1] and gnt_idx[0] drive the decoder's a, b and c inputs.
- gnt_valid gates the decoded one-hot select.
- Holds each grant until the owner signals done, or until a watchdog timeout expires.

Parameters:
- N, 8, number of requesters. Fixed at 8 to match the 3-bit index.
- IDXW, 3, width of the grant index.
- TIMEOUT, 16, maximum number of GRANT cycles before a forced release. 0 disables the watchdog. Legal range 0..255.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- req  input  8  request vector; bit i is requester i.
- done  input  1  the current owner releases the grant. Sampled only in GRANT.
- gnt_idx  output  3  index of the granted requester. Registered.
- gnt_valid  output  1  high while a grant is held. Registered.
- timeout  output  1  one-cycle pulse when the watchdog forces a release. Registered.

Behaviour:
- Reset (asynchronous, on rst high), state after reset:
  - state=IDLE
  - gnt_idx=0, gnt_valid=0, timeout=0
  - ptr=0 (internal search start)
  - cnt=0 (internal watchdog counter, 8 bits)
- Reset asserted mid-grant aborts the grant immediately. No timeout pulse is produced.
- State IDLE:
  - req==0: stay in IDLE.
  - Otherwise select the first set bit searching ptr, ptr+1, ..., wrapping 7->0.
  - Next edge: gnt_idx=selected, gnt_valid=1, cnt=0, state=GRANT.
  - Latency: req sampled at edge t gives gnt_valid high after edge t.
- State GRANT:
  - gnt_idx and gnt_valid are held stable.
  - req changes, including the owner dropping its req, are ignored.
  - done=1 at an edge: state=IDLE, gnt_valid=0, ptr=(gnt_idx+1) mod 8.
  - Otherwise, if TIMEOUT!=0 and cnt==TIMEOUT-1: same release as done, plus timeout=1 for one cycle.
  - Otherwise cnt=cnt+1.
- Simultaneous events:
  - done and watchdog expiry in the same cycle: done wins and timeout stays 0.
- Release gap: after any release, gnt_valid is low for at least one full cycle (the IDLE cycle) before the next grant.
- gnt_idx keeps its last value while idle and only changes on a new grant.
- done in IDLE is ignored.
- Fairness: after releasing index k, requester k has the lowest priority. Every requester holding req continuously is granted within 8 grants.
- Wrap-around: releasing index 7 sets ptr=0.
- timeout is 0 in all cycles other than the forced-release pulse.

Test Plan:
- Reset, then req=8'b0000_0100 -> one edge later gnt_idx=2, gnt_valid=1. Pulse done=1 -> gnt_valid=0 next cycle. ptr=3 internally.
- req=8'hFF held, done pulsed once per grant -> grant sequence 0,1,2,3,4,5,6,7,0. Each grant is separated by one gnt_valid=0 cycle.
- Granted to 5. Drop req[5], raise req[1] mid-grant -> gnt_idx stays 5 until done. Next grant is 1.
- TIMEOUT=16, grant to 3, done never asserted -> gnt_valid high for exactly 16 cycles. timeout=1 for one cycle coincident with the gnt_valid fall. Next search starts at 4.
- done asserted on the cycle of watchdog expiry -> release with timeout=0.
- rst asserted asynchronously (between clock edges) while in GRANT with gnt_idx=6 -> gnt_idx=0, gnt_valid=0, timeout=0 immediately. With req=8'h40 held, after rst deasserts the first grant is 6.

Source files
------------

// File: rtl/rr_grant_encoder.sv
// 8-way round-robin arbiter emitting a registered binary grant index, valid flag and watchdog pulse.
// One-cycle grant latency from req; a grant is held until done or watchdog expiry, then one idle cycle.
module rr_grant_encoder #(
  parameter int N       = 8,
  parameter int IDXW    = 3,
  parameter int TIMEOUT = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [N-1:0]    req,
  input  logic            done,
  output logic [IDXW-1:0] gnt_idx,
  output logic            gnt_valid,
  output logic            timeout
);

  typedef enum logic {S_IDLE, S_GRANT} state_t;

  state_t          r_state;
  logic [IDXW-1:0] r_ptr;
  logic [IDXW-1:0] r_gnt_idx;
  logic            r_gnt_valid;
  logic            r_timeout;
  logic [7:0]      r_cnt;

  logic [IDXW-1:0] w_sel;
  logic [IDXW-1:0] w_cand;
  logic            w_any;
  logic            w_expire;

  // Rotating priority search: candidates ptr, ptr+1, ... wrap naturally in IDXW bits.
  always_comb begin
    w_sel  = r_ptr;
    w_cand = r_ptr;
    w_any  = 1'b0;
    for (int i = 0; i < N; i++) begin
      w_cand = r_ptr + IDXW'(i);
      if (!w_any && req[w_cand]) begin
        w_sel = w_cand;
        w_any = 1'b1;
      end
    end
  end

  assign w_expire = (TIMEOUT != 0) && (r_cnt == 8'(TIMEOUT - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_ptr       <= '0;
      r_gnt_idx   <= '0;
      r_gnt_valid <= 1'b0;
      r_timeout   <= 1'b0;
      r_cnt       <= '0;
    end else begin
      r_timeout <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_any) begin
            r_gnt_idx   <= w_sel;
            r_gnt_valid <= 1'b1;
            r_cnt       <= '0;
            r_state     <= S_GRANT;
          end
        end
        S_GRANT: begin
          // done takes precedence over the watchdog so an on-time release never flags a timeout.
          if (done || w_expire) begin
            r_state     <= S_IDLE;
            r_gnt_valid <= 1'b0;
            r_ptr       <= r_gnt_idx + IDXW'(1);
            r_timeout   <= !done;
          end else begin
            r_cnt <= r_cnt + 8'd1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign gnt_idx   = r_gnt_idx;
  assign gnt_valid = r_gnt_valid;
  assign timeout   = r_timeout;

endmodule

// File: tb/tb_rr_grant_encoder.sv
// Bench for rr_grant_encoder: directed vectors, literal checks, and a per-cycle behavioural model compare.
module tb_rr_grant_encoder;

  localparam int TO = 16;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] req = 8'h00;
  logic       done = 1'b0;
  logic [2:0] gnt_idx;
  logic       gnt_valid;
  logic       timeout;

  int checks   = 0;
  int failures = 0;

  // Behavioural model state (plain integers)
  bit m_busy = 1'b0;
  int m_idx  = 0;
  int m_ptr  = 0;
  int m_held = 0;
  bit m_to   = 1'b0;

  rr_grant_encoder #(.N(8), .IDXW(3), .TIMEOUT(TO)) dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .done      (done),
    .gnt_idx   (gnt_idx),
    .gnt_valid (gnt_valid),
    .timeout   (timeout)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", nm, act, exp);
    end
  endtask

  function automatic int first_from(input int start, input logic [7:0] r);
    for (int k = 0; k < 8; k++) begin
      if (r[(start + k) % 8]) return (start + k) % 8;
    end
    return -1;
  endfunction

  // Model: m_held counts completed grant cycles; a grant lives at most TO cycles.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_busy <= 1'b0;
      m_idx  <= 0;
      m_ptr  <= 0;
      m_held <= 0;
      m_to   <= 1'b0;
    end else begin
      m_to <= 1'b0;
      if (m_busy) begin
        if (done) begin
          m_busy <= 1'b0;
          m_ptr  <= (m_idx + 1) % 8;
        end else if (TO != 0 && m_held + 1 >= TO) begin
          m_busy <= 1'b0;
          m_ptr  <= (m_idx + 1) % 8;
          m_to   <= 1'b1;
        end else begin
          m_held <= m_held + 1;
        end
      end else if (req != 8'h00) begin
        m_idx  <= first_from(m_ptr, req);
        m_busy <= 1'b1;
        m_held <= 0;
      end
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      chk("model_idx", int'(gnt_idx), m_idx);
      chk("model_valid", int'(gnt_valid), int'(m_busy));
      chk("model_timeout", int'(timeout), int'(m_to));
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1);
  end

  initial begin
    int seq [9];
    int hi;
    seq = '{0, 1, 2, 3, 4, 5, 6, 7, 0};

    // Reset state
    rst = 1'b1; req = 8'h00; done = 1'b0;
    cyc(); cyc();
    chk("rst_idx", int'(gnt_idx), 0);
    chk("rst_valid", int'(gnt_valid), 0);
    chk("rst_timeout", int'(timeout), 0);
    rst = 1'b0;

    // Single request, release, ptr advances to 3
    req = 8'b0000_0100;
    cyc();
    chk("t1_valid", int'(gnt_valid), 1);
    chk("t1_idx", int'(gnt_idx), 2);
    req = 8'h00; done = 1'b1;
    cyc();
    chk("t1_release", int'(gnt_valid), 0);
    done = 1'b0; req = 8'h09;
    cyc();
    chk("t1_ptr3_idx", int'(gnt_idx), 3);
    done = 1'b1; req = 8'h00;
    cyc();
    done = 1'b0;
    chk("idle_keeps_idx", int'(gnt_idx), 3);
    done = 1'b1;
    cyc();
    chk("done_in_idle", int'(gnt_valid), 0);
    done = 1'b0;

    // Full rotation with all requesters active
    rst = 1'b1;
    cyc();
    rst = 1'b0; req = 8'hFF;
    for (int i = 0; i < 9; i++) begin
      cyc();
      chk("rot_valid", int'(gnt_valid), 1);
      chk("rot_idx", int'(gnt_idx), seq[i]);
      done = 1'b1;
      cyc();
      chk("rot_gap", int'(gnt_valid), 0);
      done = 1'b0;
      if (i == 8) req = 8'h00;
    end

    // Request changes mid-grant are ignored
    req = 8'h20;
    cyc();
    chk("hold_idx5", int'(gnt_idx), 5);
    req = 8'h02;
    repeat (3) begin
      cyc();
      chk("hold_stable", int'(gnt_idx), 5);
    end
    done = 1'b1;
    cyc();
    done = 1'b0;
    cyc();
    chk("after_hold_idx", int'(gnt_idx), 1);
    done = 1'b1; req = 8'h00;
    cyc();
    done = 1'b0;

    // Watchdog expiry on grant 3
    req = 8'h08;
    cyc();
    chk("wd_idx3", int'(gnt_idx), 3);
    req = 8'h09;
    hi = 1;
    for (int n = 0; n < 40; n++) begin
      cyc();
      if (!gnt_valid) break;
      hi++;
    end
    chk("wd_hold_cycles", hi, 16);
    chk("wd_pulse", int'(timeout), 1);
    cyc();
    chk("wd_pulse_clear", int'(timeout), 0);
    chk("wd_next_from4", int'(gnt_idx), 0);
    done = 1'b1; req = 8'h00;
    cyc();
    done = 1'b0;

    // done coincident with watchdog expiry
    req = 8'h01;
    cyc();
    chk("coin_idx0", int'(gnt_idx), 0);
    req = 8'h00;
    repeat (15) cyc();
    chk("coin_still_valid", int'(gnt_valid), 1);
    done = 1'b1;
    cyc();
    chk("coin_release", int'(gnt_valid), 0);
    chk("coin_no_timeout", int'(timeout), 0);
    done = 1'b0;

    // Asynchronous reset mid-grant
    req = 8'h40;
    cyc();
    chk("ar_idx6", int'(gnt_idx), 6);
    #3;
    rst = 1'b1;
    #1;
    chk("ar_idx", int'(gnt_idx), 0);
    chk("ar_valid", int'(gnt_valid), 0);
    chk("ar_timeout", int'(timeout), 0);
    cyc();
    rst = 1'b0;
    cyc();
    chk("ar_regrant_valid", int'(gnt_valid), 1);
    chk("ar_regrant_idx", int'(gnt_idx), 6);

    req = 8'h00; done = 1'b1;
    cyc();
    done = 1'b0;
    cyc();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
